// File: rtl/floo_vc_credit_tx.sv
// Transmit endpoint of a credit-based virtual-channel link.
// Turns an upstream valid/ready flit stream into valid + VC-id flits on the link.
// It keeps one credit counter per downstream VC buffer and picks a VC for each
// head flit, optionally overflowing onto another VC that still has credit.
// Multi-flit bursts stay on the VC of their head flit until the tail flit is sent.
module floo_vc_credit_tx #(
  parameter int unsigned NumVC           = 2,     // VCs on the link, 1..8
  parameter int unsigned VCDepth         = 2,     // downstream buffer depth per VC
  parameter int unsigned VCIdWidth       = 3,     // 2**VCIdWidth must be >= NumVC
  parameter bit          AllowVCOverflow = 1'b1,  // fall back to any VC with credit
  parameter bit          CreditShortcut  = 1'b0,  // same-cycle use of returned credit
  parameter type         flit_t          = logic
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // upstream flit stream
  input  logic                 valid_i,
  output logic                 ready_o,
  input  flit_t                data_i,
  input  logic                 last_i,
  input  logic [VCIdWidth-1:0] vc_pref_i,
  // link side
  output logic                 valid_o,
  output flit_t                data_o,
  output logic [VCIdWidth-1:0] vc_id_o,
  input  logic                 credit_valid_i,
  input  logic [VCIdWidth-1:0] credit_id_i,
  // status
  output logic                 idle_o,
  output logic                 credit_err_o
);

  // Counter must hold 0..VCDepth inclusive.
  localparam int unsigned CntW = (VCDepth < 1) ? 1 : $clog2(VCDepth + 1);

  typedef logic [CntW-1:0]      cnt_t;
  typedef logic [VCIdWidth-1:0] vc_id_t;

  localparam cnt_t CntMax = cnt_t'(VCDepth);
  localparam cnt_t CntOne = cnt_t'(1);

  // Credit state
  cnt_t   cnt_q [NumVC];
  cnt_t   cnt_d [NumVC];
  logic   err_q, err_d;
  logic   idle_q, idle_d;

  // Wormhole lock state
  logic   lock_q, lock_d;
  vc_id_t lock_vc_q, lock_vc_d;

  // Link output register
  logic   valid_q;
  flit_t  data_q;
  vc_id_t vc_id_q;

  // Per-cycle decode
  logic [NumVC-1:0] ret_vec;    // in-range credit return, one-hot by VC
  logic             ret_oob;    // credit return with an id beyond NumVC-1
  logic [NumVC-1:0] avail;      // VC may send a flit this cycle
  logic [NumVC-1:0] send_vec;   // VC sends a flit this cycle
  vc_id_t           pref_vc;    // preferred VC after range folding
  logic             pref_avail;
  logic             lock_avail;
  logic             ovf_found;
  vc_id_t           ovf_vc;
  vc_id_t           sel_vc;
  logic             sel_ok;
  logic             accept;

  // Decode the credit return into a per-VC strobe and an out-of-range flag.
  always_comb begin
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    ret_vec = '0;
    for (int v = 0; v < NumVC; v++) begin
      ret_vec[v] = credit_valid_i && (credit_id_i == vc_id_t'(v));
    end
    ret_oob = credit_valid_i && (int'(credit_id_i) >= int'(NumVC));
  end

  // Effective credit per VC; the shortcut lets a credit arriving now be spent now.
  always_comb begin
    avail = '0;
    for (int v = 0; v < NumVC; v++) begin
      avail[v] = (cnt_q[v] != '0) || (CreditShortcut && ret_vec[v]);
    end
  end

  // Look up credit for the preferred and locked VCs and find the overflow candidate.
  always_comb begin
    pref_vc    = (int'(vc_pref_i) < int'(NumVC)) ? vc_pref_i : '0;
    pref_avail = 1'b0;
    lock_avail = 1'b0;
    ovf_found  = 1'b0;
    ovf_vc     = '0;
    for (int v = 0; v < NumVC; v++) begin
      if (vc_id_t'(v) == pref_vc) begin
        pref_avail = avail[v];
      end
      if (vc_id_t'(v) == lock_vc_q) begin
        lock_avail = avail[v];
      end
      // First hit in ascending order is the lowest-index VC with credit.
      if (avail[v] && !ovf_found) begin
        ovf_found = 1'b1;
        ovf_vc    = vc_id_t'(v);
      end
    end
  end

  // Choose the VC for the flit at the input: locked VC, else preferred, else overflow.
  always_comb begin
    sel_vc = pref_vc;
    sel_ok = 1'b0;
    if (lock_q) begin
      // Body and tail flits never leave the head's VC, even if it runs dry.
      sel_vc = lock_vc_q;
      sel_ok = lock_avail;
    end else if (pref_avail) begin
      sel_vc = pref_vc;
      sel_ok = 1'b1;
    end else if (AllowVCOverflow && ovf_found) begin
      sel_vc = ovf_vc;
      sel_ok = 1'b1;
    end
  end

  // Handshake: ready depends only on credit state, never on valid_i.
  always_comb begin
    ready_o  = sel_ok && !rst_i;
    accept   = valid_i && ready_o;
    send_vec = '0;
    for (int v = 0; v < NumVC; v++) begin
      send_vec[v] = accept && (sel_vc == vc_id_t'(v));
    end
  end

  // Credit counters: take one on send, give one back on return, saturate on overflow.
  always_comb begin
    err_d = err_q || ret_oob;
    for (int v = 0; v < NumVC; v++) begin
      cnt_d[v] = cnt_q[v];
      unique case ({send_vec[v], ret_vec[v]})
        2'b10: cnt_d[v] = cnt_q[v] - CntOne;
        2'b01: begin
          if (cnt_q[v] == CntMax) begin
            // Downstream returned more credits than it owns: hold and flag.
            err_d = 1'b1;
          end else begin
            cnt_d[v] = cnt_q[v] + CntOne;
          end
        end
        default: cnt_d[v] = cnt_q[v];  // idle, or send and return cancel out
      endcase
    end
  end

  // Lock tracking: a non-tail flit locks its VC, a tail flit releases it.
  always_comb begin
    lock_d    = lock_q;
    lock_vc_d = lock_vc_q;
    if (accept) begin
      lock_d    = !last_i;
      lock_vc_d = sel_vc;
    end
  end

  // Idle is judged on the state the registers are about to take.
  always_comb begin
    idle_d = !lock_d;
    for (int v = 0; v < NumVC; v++) begin
      if (cnt_d[v] != CntMax) begin
        idle_d = 1'b0;
      end
    end
  end

  // Credit, lock and status registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    if (rst_i) begin
      // NOTE: the counter array is a handful of flops, not a RAM, so it is
      // reset element by element to the full downstream buffer depth.
      for (int v = 0; v < NumVC; v++) begin
        cnt_q[v] <= CntMax;
      end
      lock_q    <= 1'b0;
      lock_vc_q <= '0;
      err_q     <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      for (int v = 0; v < NumVC; v++) begin
        cnt_q[v] <= cnt_d[v];
      end
      lock_q    <= lock_d;
      lock_vc_q <= lock_vc_d;
      err_q     <= err_d;
      idle_q    <= idle_d;
    end
  end

  // Link output register: one cycle of latency, payload held between flits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      vc_id_q <= '0;
    end else begin
      valid_q <= accept;
      if (accept) begin
        data_q  <= data_i;
        vc_id_q <= sel_vc;
      end
    end
  end

  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign vc_id_o      = vc_id_q;
  assign idle_o       = idle_q;
  assign credit_err_o = err_q;

endmodule

// File: tb/tb_floo_vc_credit_tx.sv
// Self-checking bench for floo_vc_credit_tx.
// Three instances share one stimulus bus: 0 = preferred VC only, 1 = preferred VC
// only with credit shortcut, 2 = overflow enabled. Each table row names the
// instance it checks; every sequence begins with a reset row, so the unchecked
// instances simply follow along. Accepted flits are pushed to a scoreboard and
// popped one cycle later when the link output is sampled.
module tb_floo_vc_credit_tx;

  typedef logic [7:0] flit8_t;

  typedef struct {
    int         dut;
    bit         rst;
    bit         vld;
    flit8_t     data;
    bit         last;
    logic [2:0] pref;
    bit         cv;
    logic [2:0] cid;
    bit         e_rdy;
    logic [2:0] e_vc;
    bit         e_idle;
    bit         e_err;
  } vec_t;

  typedef struct packed {
    flit8_t     data;
    logic [2:0] vc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_in;
  logic       valid_in;
  flit8_t     data_in;
  logic       last_in;
  logic [2:0] pref_in;
  logic       cv_in;
  logic [2:0] cid_in;

  logic       rdy_w  [3];
  logic       vld_w  [3];
  flit8_t     dat_w  [3];
  logic [2:0] vc_w   [3];
  logic       idle_w [3];
  logic       err_w  [3];

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   after_rst = 1'b0;

  always #5 clk = ~clk;

  floo_vc_credit_tx #(
    .NumVC(2), .VCDepth(2), .VCIdWidth(3),
    .AllowVCOverflow(1'b0), .CreditShortcut(1'b0), .flit_t(flit8_t)
  ) u_dut0 (
    .clk_i(clk), .rst_i(rst_in), .valid_i(valid_in), .ready_o(rdy_w[0]),
    .data_i(data_in), .last_i(last_in), .vc_pref_i(pref_in),
    .valid_o(vld_w[0]), .data_o(dat_w[0]), .vc_id_o(vc_w[0]),
    .credit_valid_i(cv_in), .credit_id_i(cid_in),
    .idle_o(idle_w[0]), .credit_err_o(err_w[0])
  );

  floo_vc_credit_tx #(
    .NumVC(2), .VCDepth(2), .VCIdWidth(3),
    .AllowVCOverflow(1'b0), .CreditShortcut(1'b1), .flit_t(flit8_t)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst_in), .valid_i(valid_in), .ready_o(rdy_w[1]),
    .data_i(data_in), .last_i(last_in), .vc_pref_i(pref_in),
    .valid_o(vld_w[1]), .data_o(dat_w[1]), .vc_id_o(vc_w[1]),
    .credit_valid_i(cv_in), .credit_id_i(cid_in),
    .idle_o(idle_w[1]), .credit_err_o(err_w[1])
  );

  floo_vc_credit_tx #(
    .NumVC(2), .VCDepth(2), .VCIdWidth(3),
    .AllowVCOverflow(1'b1), .CreditShortcut(1'b0), .flit_t(flit8_t)
  ) u_dut2 (
    .clk_i(clk), .rst_i(rst_in), .valid_i(valid_in), .ready_o(rdy_w[2]),
    .data_i(data_in), .last_i(last_in), .vc_pref_i(pref_in),
    .valid_o(vld_w[2]), .data_o(dat_w[2]), .vc_id_o(vc_w[2]),
    .credit_valid_i(cv_in), .credit_id_i(cid_in),
    .idle_o(idle_w[2]), .credit_err_o(err_w[2])
  );

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (row %0d): got %0h, expected %0h", name, row, act, exp);
    end
  endtask

  function automatic void add(int dut, bit r, bit vld, int data, bit last, int pref,
                              bit cv, int cid, bit e_rdy, int e_vc, bit e_idle,
                              bit e_err);
    vec_t v;
    v.dut = dut;  v.rst = r;  v.vld = vld;  v.data = flit8_t'(data);
    v.last = last;  v.pref = 3'(pref);  v.cv = cv;  v.cid = 3'(cid);
    v.e_rdy = e_rdy;  v.e_vc = 3'(e_vc);  v.e_idle = e_idle;  v.e_err = e_err;
    vecs.push_back(v);
  endfunction

  function automatic void add_rst(int dut);
    add(dut, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // Drive one row at the falling edge, then check registered outputs from the
  // previous rising edge and the combinational ready for this row's inputs.
  task automatic apply(input vec_t v, input int row);
    exp_t e;
    @(negedge clk);
    rst_in   = v.rst;
    valid_in = v.vld;
    data_in  = v.data;
    last_in  = v.last;
    pref_in  = v.pref;
    cv_in    = v.cv;
    cid_in   = v.cid;
    #1;
    check("ready", row, 32'(rdy_w[v.dut]), 32'(v.e_rdy));
    if (v.rst) begin
      sb.delete();
      after_rst = 1'b1;
      return;
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("valid_o", row, 32'(vld_w[v.dut]), 32'd1);
      check("data_o", row, 32'(dat_w[v.dut]), 32'(e.data));
      check("vc_id_o", row, 32'(vc_w[v.dut]), 32'(e.vc));
    end else begin
      check("valid_o", row, 32'(vld_w[v.dut]), 32'd0);
    end
    if (after_rst) begin
      check("rst_data_o", row, 32'(dat_w[v.dut]), 32'd0);
      check("rst_vc_id_o", row, 32'(vc_w[v.dut]), 32'd0);
      after_rst = 1'b0;
    end
    check("idle_o", row, 32'(idle_w[v.dut]), 32'(v.e_idle));
    check("credit_err_o", row, 32'(err_w[v.dut]), 32'(v.e_err));
    if (v.vld && v.e_rdy) begin
      sb.push_back('{data: v.data, vc: v.e_vc});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1;  valid_in = 1'b0;  data_in = '0;  last_in = 1'b1;
    pref_in = '0;   cv_in = 1'b0;     cid_in = '0;

    // dut, rst, vld, data, last, pref, cv, cid, e_rdy, e_vc, e_idle, e_err
    // Preferred VC only: two credits, third flit waits for a return (no shortcut).
    add_rst(0);
    add(0, 0, 1, 'h11, 1, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 1, 'h12, 1, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 'h13, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 'h13, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 'h13, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 'h13, 1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 'h13, 1, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0,    1, 0, 0, 0, 0, 0, 0, 0);

    // Same with the credit shortcut: the return is spendable in its own cycle.
    add_rst(1);
    add(1, 0, 1, 'h21, 1, 0, 0, 0, 1, 0, 1, 0);
    add(1, 0, 1, 'h22, 1, 0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 1, 'h23, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 'h23, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 'h23, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 'h23, 1, 0, 1, 0, 1, 0, 0, 0);
    add(1, 0, 1, 'h24, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0,    1, 0, 0, 0, 0, 0, 0, 0);

    // Overflow: VC0 drains, then VC1; out-of-range preference folds to VC0.
    add_rst(2);
    add(2, 0, 1, 'h31, 1, 0, 0, 0, 1, 0, 1, 0);
    add(2, 0, 1, 'h32, 1, 0, 0, 0, 1, 0, 0, 0);
    add(2, 0, 1, 'h33, 1, 0, 0, 0, 1, 1, 0, 0);
    add(2, 0, 1, 'h34, 1, 0, 0, 0, 1, 1, 0, 0);
    add(2, 0, 1, 'h35, 1, 0, 0, 0, 0, 0, 0, 0);
    add(2, 0, 0, 0,    1, 0, 1, 0, 0, 0, 0, 0);
    add(2, 0, 0, 0,    1, 0, 1, 1, 1, 0, 0, 0);
    add(2, 0, 1, 'h36, 1, 5, 0, 0, 1, 0, 0, 0);
    add(2, 0, 1, 'h37, 1, 1, 0, 0, 1, 1, 0, 0);
    add(2, 0, 0, 0,    1, 0, 0, 0, 0, 0, 0, 0);

    // Three-flit burst locked on VC1; no overflow to VC0 while locked.
    add_rst(2);
    add(2, 0, 1, 'h41, 0, 1, 0, 0, 1, 1, 1, 0);
    add(2, 0, 1, 'h42, 0, 0, 0, 0, 1, 1, 0, 0);
    add(2, 0, 1, 'h43, 1, 0, 0, 0, 0, 0, 0, 0);
    add(2, 0, 1, 'h43, 1, 1, 1, 1, 0, 0, 0, 0);
    add(2, 0, 1, 'h43, 1, 0, 0, 0, 1, 1, 0, 0);
    add(2, 0, 1, 'h44, 1, 0, 0, 0, 1, 0, 0, 0);
    add(2, 0, 0, 0,    1, 0, 0, 0, 1, 0, 0, 0);

    // Send and return on VC0 in the same cycle at count 1: no bubble.
    add_rst(0);
    add(0, 0, 1, 'h51, 1, 0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 1, 'h52, 1, 0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 'h53, 1, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 'h54, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,    1, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0,    1, 0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0,    1, 0, 0, 0, 1, 0, 1, 0);

    // Return onto a full counter: sticky error, count saturates at 2.
    add_rst(0);
    add(0, 0, 0, 0,    1, 0, 1, 0, 1, 0, 1, 0);
    add(0, 0, 0, 0,    1, 0, 0, 0, 1, 0, 1, 1);
    add(0, 0, 1, 'h61, 1, 0, 0, 0, 1, 0, 1, 1);
    add(0, 0, 1, 'h62, 1, 0, 0, 0, 1, 0, 0, 1);
    add(0, 0, 1, 'h63, 1, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0,    1, 0, 0, 0, 0, 0, 0, 1);

    // Out-of-range credit id: flagged and not credited to any VC.
    add_rst(0);
    add(0, 0, 1, 'h71, 1, 1, 0, 0, 1, 1, 1, 0);
    add(0, 0, 0, 0,    1, 1, 1, 5, 1, 0, 0, 0);
    add(0, 0, 0, 0,    1, 1, 0, 0, 1, 0, 0, 1);
    add(0, 0, 1, 'h72, 1, 1, 0, 0, 1, 1, 0, 1);
    add(0, 0, 1, 'h73, 1, 1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0,    1, 1, 0, 0, 0, 0, 0, 1);

    // Reset in the middle of a burst drops the lock and restores credit.
    add_rst(2);
    add(2, 0, 1, 'h81, 0, 1, 0, 0, 1, 1, 1, 0);
    add_rst(2);
    add(2, 0, 0, 0,    1, 0, 0, 0, 1, 0, 1, 0);
    add(2, 0, 1, 'h82, 1, 0, 0, 0, 1, 0, 1, 0);
    add(2, 0, 0, 0,    1, 0, 0, 0, 1, 0, 0, 0);

    // Full-rate stream on VC0 with each credit returned one cycle after its send.
    add_rst(2);
    for (int i = 0; i < 8; i++) begin
      add(2, 0, 1, 'h90 + i, 1, 0, (i > 0), 0, 1, 0, (i == 0), 0);
    end
    add(2, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0);
    add(2, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0);

    foreach (vecs[i]) begin
      apply(vecs[i], i);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
